// File: rtl/opfetch_pkg.sv
// Shared constants for the operand-fetch stage slice.
package opfetch_pkg;

  localparam int REG_SELECT_WIDTH_DEFAULT = 5;
  localparam int DATA_WIDTH_DEFAULT       = 32;
  localparam int STALL_COUNT_WIDTH        = 16;
  localparam int ZERO_REG                 = 0;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bus bundle between the operand-fetch stage and its neighbours: decode
// handshake, register-file read port, writeback snoop, and the execute slot.
// The slave modport is the stage; the master modport is its environment.
interface operand_fetch_stage_if import opfetch_pkg::*; #(
  parameter int REG_SELECT_WIDTH = REG_SELECT_WIDTH_DEFAULT,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT
);

  logic                                InValid;
  logic                                InReady;
  logic [REG_SELECT_WIDTH-1:0]         InSrc1;
  logic [REG_SELECT_WIDTH-1:0]         InSrc2;
  logic [REG_SELECT_WIDTH-1:0]         InDest;
  logic                                InWritesDest;
  logic [REG_SELECT_WIDTH-1:0]         ReadSelect1;
  logic [REG_SELECT_WIDTH-1:0]         ReadSelect2;
  logic [DATA_WIDTH-1:0]               ReadData1;
  logic [DATA_WIDTH-1:0]               ReadData2;
  logic                                WbEnable;
  logic [REG_SELECT_WIDTH-1:0]         WbSelect;
  logic [DATA_WIDTH-1:0]               WbData;
  logic                                OutValid;
  logic                                OutReady;
  logic [DATA_WIDTH-1:0]               OutOperand1;
  logic [DATA_WIDTH-1:0]               OutOperand2;
  logic [REG_SELECT_WIDTH-1:0]         OutDest;
  logic                                OutWritesDest;
  logic [(1<<REG_SELECT_WIDTH)-1:0]    ScoreboardBusy;
  logic [STALL_COUNT_WIDTH-1:0]        StallCount;

  modport slave (
    input  InValid, InSrc1, InSrc2, InDest, InWritesDest,
    output InReady,
    output ReadSelect1, ReadSelect2,
    input  ReadData1, ReadData2,
    input  WbEnable, WbSelect, WbData,
    output OutValid, OutOperand1, OutOperand2, OutDest, OutWritesDest,
    input  OutReady,
    output ScoreboardBusy, StallCount
  );

  modport master (
    output InValid, InSrc1, InSrc2, InDest, InWritesDest,
    input  InReady,
    input  ReadSelect1, ReadSelect2,
    output ReadData1, ReadData2,
    output WbEnable, WbSelect, WbData,
    input  OutValid, OutOperand1, OutOperand2, OutDest, OutWritesDest,
    output OutReady,
    input  ScoreboardBusy, StallCount
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard. A register is marked busy when an instruction
// writing it issues and freed when its writeback is seen. A set and a clear
// to the same register in one cycle leave it busy, because the set belongs to
// a newer instruction. Register 0 can never become busy.
module reg_scoreboard import opfetch_pkg::*; #(
  parameter int REG_SELECT_WIDTH = REG_SELECT_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             set_en,
  input  logic [REG_SELECT_WIDTH-1:0]      set_idx,
  input  logic                             clr_en,
  input  logic [REG_SELECT_WIDTH-1:0]      clr_idx,
  input  logic [REG_SELECT_WIDTH-1:0]      lookup_a,
  input  logic [REG_SELECT_WIDTH-1:0]      lookup_b,
  input  logic [REG_SELECT_WIDTH-1:0]      lookup_c,
  output logic                             busy_a,
  output logic                             busy_b,
  output logic                             busy_c,
  output logic [(1<<REG_SELECT_WIDTH)-1:0] busy
);

  localparam int NUM_REGS = 1 << REG_SELECT_WIDTH;
  localparam logic [REG_SELECT_WIDTH-1:0] ZERO_IDX = REG_SELECT_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decode the set and clear requests into one-hot vectors.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_idx != ZERO_IDX)
      set_vec[set_idx] = 1'b1;
    if (clr_en)
      clr_vec[clr_idx] = 1'b1;
  end

  // Busy vector update: clear first, then OR in the set so the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  assign busy   = busy_q;
  assign busy_a = busy_q[lookup_a];
  assign busy_b = busy_q[lookup_b];
  assign busy_c = busy_q[lookup_c];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch pipeline stage: reads both sources from the register file,
// stalls on RAW/WAW hazards tracked by a busy scoreboard, and captures the
// operands into a single registered output slot.
// Build option OPFETCH_BYPASS_EN: when defined, a writeback in the current
// cycle is forwarded to the operands and resolves the hazard without a stall.
module operand_fetch_stage import opfetch_pkg::*; #(
  parameter int REG_SELECT_WIDTH = REG_SELECT_WIDTH_DEFAULT,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT
) (
  input logic                   Clk,
  input logic                   Reset,
  operand_fetch_stage_if.slave  bus
);

  localparam logic [REG_SELECT_WIDTH-1:0] ZERO_IDX = REG_SELECT_WIDTH'(ZERO_REG);
  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX = {STALL_COUNT_WIDTH{1'b1}};

  logic busy_src1, busy_src2, busy_dest;
  logic clr_src1, clr_src2, clr_dest;
  logic src1_haz, src2_haz, dest_haz, hazard;
  logic in_ready, accept;
  logic [DATA_WIDTH-1:0] operand1, operand2;

  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_operand1_q;
  logic [DATA_WIDTH-1:0]        out_operand2_q;
  logic [REG_SELECT_WIDTH-1:0]  out_dest_q;
  logic                         out_writes_dest_q;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q;

  reg_scoreboard #(.REG_SELECT_WIDTH(REG_SELECT_WIDTH)) scoreboard (
    .clk      (Clk),
    .rst_n    (Reset),
    .set_en   (accept && bus.InWritesDest),
    .set_idx  (bus.InDest),
    .clr_en   (bus.WbEnable),
    .clr_idx  (bus.WbSelect),
    .lookup_a (bus.InSrc1),
    .lookup_b (bus.InSrc2),
    .lookup_c (bus.InDest),
    .busy_a   (busy_src1),
    .busy_b   (busy_src2),
    .busy_c   (busy_dest),
    .busy     (bus.ScoreboardBusy)
  );

  assign bus.ReadSelect1 = bus.InSrc1;
  assign bus.ReadSelect2 = bus.InSrc2;

  assign clr_src1 = bus.WbEnable && bus.WbSelect == bus.InSrc1;
  assign clr_src2 = bus.WbEnable && bus.WbSelect == bus.InSrc2;
  assign clr_dest = bus.WbEnable && bus.WbSelect == bus.InDest;

  // Hazard detection and operand selection; the writeback mux only exists in
  // the bypass build, otherwise a same-cycle writeback still counts as busy.
  always_comb begin
    operand1 = bus.ReadData1;
    operand2 = bus.ReadData2;
`ifdef OPFETCH_BYPASS_EN
    src1_haz = bus.InSrc1 != ZERO_IDX && busy_src1 && !clr_src1;
    src2_haz = bus.InSrc2 != ZERO_IDX && busy_src2 && !clr_src2;
    if (clr_src1) operand1 = bus.WbData;
    if (clr_src2) operand2 = bus.WbData;
`else
    src1_haz = bus.InSrc1 != ZERO_IDX && (busy_src1 || clr_src1);
    src2_haz = bus.InSrc2 != ZERO_IDX && (busy_src2 || clr_src2);
`endif
    if (bus.InSrc1 == ZERO_IDX) operand1 = '0;
    if (bus.InSrc2 == ZERO_IDX) operand2 = '0;
    dest_haz = bus.InWritesDest && bus.InDest != ZERO_IDX && busy_dest && !clr_dest;
    hazard   = bus.InValid && (src1_haz || src2_haz || dest_haz);
    in_ready = (!out_valid_q || bus.OutReady) && !hazard;
    accept   = bus.InValid && in_ready;
  end

  // Output slot: load on accept, drop valid on a drain without a refill.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid_q       <= 1'b0;
      out_operand1_q    <= '0;
      out_operand2_q    <= '0;
      out_dest_q        <= '0;
      out_writes_dest_q <= 1'b0;
    end else if (accept) begin
      out_valid_q       <= 1'b1;
      out_operand1_q    <= operand1;
      out_operand2_q    <= operand2;
      out_dest_q        <= bus.InDest;
      out_writes_dest_q <= bus.InWritesDest;
    end else if (out_valid_q && bus.OutReady) begin
      out_valid_q       <= 1'b0;
    end
  end

  // Saturating count of cycles lost to hazards.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      stall_count_q <= '0;
    else if (hazard && stall_count_q != STALL_MAX)
      stall_count_q <= stall_count_q + 1'b1;
  end

  assign bus.InReady       = in_ready;
  assign bus.OutValid      = out_valid_q;
  assign bus.OutOperand1   = out_operand1_q;
  assign bus.OutOperand2   = out_operand2_q;
  assign bus.OutDest       = out_dest_q;
  assign bus.OutWritesDest = out_writes_dest_q;
  assign bus.StallCount    = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed testbench for operand_fetch_stage with a behavioural register file
// on the read/writeback ports. Expectations follow OPFETCH_BYPASS_EN when the
// macro is defined for the build.
module tb_operand_fetch_stage;
  import opfetch_pkg::*;

  logic Clk;
  logic Reset;
  int   testsRun;
  int   testsFailed;
  int   expStall;
  logic [31:0] rf [32];

  operand_fetch_stage_if #(.REG_SELECT_WIDTH(5), .DATA_WIDTH(32)) bus ();

  operand_fetch_stage #(.REG_SELECT_WIDTH(5), .DATA_WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural register file written by the same writeback port.
  always @(posedge Clk) begin
    if (bus.WbEnable)
      rf[bus.WbSelect] <= bus.WbData;
  end

  assign bus.ReadData1 = rf[bus.ReadSelect1];
  assign bus.ReadData2 = rf[bus.ReadSelect2];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] src1,
                               input logic [4:0] src2, input logic [4:0] dest,
                               input logic writesDest);
    bus.InValid      = valid;
    bus.InSrc1       = src1;
    bus.InSrc2       = src2;
    bus.InDest       = dest;
    bus.InWritesDest = writesDest;
    #1;
  endtask

  task automatic applyWb(input logic en, input logic [4:0] sel, input logic [31:0] data);
    bus.WbEnable = en;
    bus.WbSelect = sel;
    bus.WbData   = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    Reset       = 1'b0;
    bus.OutReady = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyWb(0, 0, 0);

    // Reset state
    checkOutput("reset_outvalid", 32'(bus.OutValid), 32'h0);
    checkOutput("reset_op1", bus.OutOperand1, 32'h0);
    checkOutput("reset_busy", bus.ScoreboardBusy, 32'h0);
    checkOutput("reset_stall", 32'(bus.StallCount), 32'h0);
    tick();
    Reset = 1'b1;

    // Preload r1, r2, r5 through the writeback port
    applyWb(1, 1, 32'h11); tick();
    applyWb(1, 2, 32'h22); tick();
    applyWb(1, 5, 32'h5A5A); tick();
    applyWb(0, 0, 0);

    // Back-to-back independent issue
    applyStimulus(1, 1, 2, 3, 1);
    checkOutput("b2b_ready0", 32'(bus.InReady), 32'h1);
    tick();
    checkOutput("b2b_op1_a", bus.OutOperand1, 32'h11);
    checkOutput("b2b_op2_a", bus.OutOperand2, 32'h22);
    checkOutput("b2b_dest_a", 32'(bus.OutDest), 32'h3);
    applyStimulus(1, 2, 1, 4, 1);
    checkOutput("b2b_ready1", 32'(bus.InReady), 32'h1);
    tick();
    checkOutput("b2b_op1_b", bus.OutOperand1, 32'h22);
    checkOutput("b2b_op2_b", bus.OutOperand2, 32'h11);
    checkOutput("b2b_busy", bus.ScoreboardBusy, 32'h18);

    // RAW on r3
    applyStimulus(1, 3, 0, 5, 1);
    checkOutput("raw_stall_ready", 32'(bus.InReady), 32'h0);
    tick();
    tick();
    checkOutput("raw_stallcount", 32'(bus.StallCount), 32'h2);
    checkOutput("raw_slot_drained", 32'(bus.OutValid), 32'h0);
    applyWb(1, 3, 32'hDEAD);
`ifdef OPFETCH_BYPASS_EN
    checkOutput("raw_wb_ready", 32'(bus.InReady), 32'h1);
    expStall = 2;
    tick();
    applyWb(0, 0, 0);
`else
    checkOutput("raw_wb_ready", 32'(bus.InReady), 32'h0);
    expStall = 3;
    tick();
    applyWb(0, 0, 0);
    checkOutput("raw_late_ready", 32'(bus.InReady), 32'h1);
    tick();
`endif
    checkOutput("raw_outvalid", 32'(bus.OutValid), 32'h1);
    checkOutput("raw_op1", bus.OutOperand1, 32'hDEAD);
    checkOutput("raw_dest", 32'(bus.OutDest), 32'h5);
    checkOutput("raw_stall_final", 32'(bus.StallCount), 32'(expStall));
    checkOutput("raw_busy", bus.ScoreboardBusy, 32'h30);

    // Register 0 with a concurrent writeback to r0
    applyStimulus(1, 0, 0, 0, 1);
    applyWb(1, 0, 32'h55);
    checkOutput("r0_ready", 32'(bus.InReady), 32'h1);
    tick();
    applyWb(0, 0, 0);
    checkOutput("r0_op1", bus.OutOperand1, 32'h0);
    checkOutput("r0_busy", bus.ScoreboardBusy, 32'h30);
    checkOutput("r0_stall", 32'(bus.StallCount), 32'(expStall));

    // Set and clear of r7 in the same cycle
    applyStimulus(1, 0, 0, 7, 1);
    tick();
    checkOutput("sc_busy_set", bus.ScoreboardBusy, 32'hB0);
    applyWb(1, 7, 32'h77);
    checkOutput("sc_ready", 32'(bus.InReady), 32'h1);
    tick();
    checkOutput("sc_busy_setwins", bus.ScoreboardBusy, 32'hB0);
    applyStimulus(0, 0, 0, 0, 0);
    applyWb(1, 7, 32'h78);
    tick();
    applyWb(0, 0, 0);
    checkOutput("sc_busy_cleared", bus.ScoreboardBusy, 32'h30);
    checkOutput("sc_drained", 32'(bus.OutValid), 32'h0);

    // Back-pressure
    bus.OutReady = 1'b0;
    applyStimulus(1, 1, 2, 8, 1);
    tick();
    checkOutput("bp_first_op1", bus.OutOperand1, 32'h11);
    applyStimulus(1, 2, 1, 9, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_ready_low", 32'(bus.InReady), 32'h0);
      tick();
      checkOutput("bp_hold_valid", 32'(bus.OutValid), 32'h1);
      checkOutput("bp_hold_op1", bus.OutOperand1, 32'h11);
      checkOutput("bp_hold_dest", 32'(bus.OutDest), 32'h8);
    end
    checkOutput("bp_no_stall", 32'(bus.StallCount), 32'(expStall));
    bus.OutReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(bus.InReady), 32'h1);
    tick();
    checkOutput("bp_next_op1", bus.OutOperand1, 32'h22);
    checkOutput("bp_next_dest", 32'(bus.OutDest), 32'h9);

    // Saturation: reader of busy r5 stalls for 70000 cycles
    applyStimulus(1, 5, 0, 0, 0);
    repeat (70000) @(posedge Clk);
    #1;
    checkOutput("sat_stallcount", 32'(bus.StallCount), 32'hFFFF);
    checkOutput("sat_ready", 32'(bus.InReady), 32'h0);

    // Asynchronous reset in the middle of the stall
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("rst_outvalid", 32'(bus.OutValid), 32'h0);
    checkOutput("rst_op1", bus.OutOperand1, 32'h0);
    checkOutput("rst_op2", bus.OutOperand2, 32'h0);
    checkOutput("rst_dest", 32'(bus.OutDest), 32'h0);
    checkOutput("rst_wd", 32'(bus.OutWritesDest), 32'h0);
    checkOutput("rst_busy", bus.ScoreboardBusy, 32'h0);
    checkOutput("rst_stall", 32'(bus.StallCount), 32'h0);
    tick();
    Reset = 1'b1;
    #1;
    checkOutput("post_rst_ready", 32'(bus.InReady), 32'h1);
    tick();
    checkOutput("post_rst_op1", bus.OutOperand1, 32'h5A5A);
    checkOutput("post_rst_stall", 32'(bus.StallCount), 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
